// File: rtl/openip_rr_stream_arbiter_if.sv
// Stream bundle between N upstream requesters and one downstream sink.
// The arbiter takes the slave view; the traffic source/sink side takes the master view.
interface openip_rr_stream_arbiter_if #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
);
  logic [NUM_INPUTS-1:0]            in_valid;
  logic [NUM_INPUTS-1:0]            in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]            in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_last;
  logic [IDX_WIDTH-1:0]             out_sel;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/openip_rr_stream_arbiter.sv
// N:1 valid/ready stream arbiter: round-robin between packets, grant locked for
// the duration of a packet (and of any stalled beat). Zero-latency data path.
module openip_rr_stream_arbiter #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  openip_rr_stream_arbiter_if.slave bus
);
  localparam int unsigned N = NUM_INPUTS;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
  logic [N-1:0]         rr_mask_q, rr_mask_d;

  logic [N-1:0]          masked_c, grant_c, lock_oh_c;
  logic [IDX_WIDTH-1:0]  sel_c;
  logic                  out_valid_c, out_last_c, hs_c;
  logic [DATA_WIDTH-1:0] out_data_c;

  // Bits strictly above k stay eligible for the high-priority pass.
  function automatic logic [N-1:0] mask_above(input logic [IDX_WIDTH-1:0] k);
    logic [N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N; i++) m[i] = (IDX_WIDTH'(i) > k);
    return m;
  endfunction

  // Rotating-priority pick in IDLE; fixed pick while a packet or stalled beat holds the lock.
  always_comb begin
    masked_c  = bus.in_valid & rr_mask_q;
    lock_oh_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (lock_idx_q == IDX_WIDTH'(i)) lock_oh_c[i] = 1'b1;
    end
    if (state_q == ST_LOCKED)      grant_c = lock_oh_c;
    else if (|masked_c)            grant_c = masked_c & (~masked_c + N'(1));
    else                           grant_c = bus.in_valid & (~bus.in_valid + N'(1));

    sel_c = (state_q == ST_LOCKED) ? lock_idx_q : '0;
    if (state_q == ST_IDLE) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (grant_c[i]) sel_c = IDX_WIDTH'(i);
      end
    end

    out_valid_c = (state_q == ST_LOCKED) ? |(bus.in_valid & lock_oh_c) : |bus.in_valid;

    // Pure mux: unselected inputs never reach the output.
    out_data_c = '0;
    out_last_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_c == IDX_WIDTH'(i)) begin
        out_data_c = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        out_last_c = bus.in_last[i];
      end
    end

    hs_c = out_valid_c & bus.out_ready;
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_mask_d  = rr_mask_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_c && out_last_c) begin
          rr_mask_d = mask_above(sel_c);
        end else if (out_valid_c) begin
          state_d    = ST_LOCKED;
          lock_idx_d = sel_c;
        end
      end
      ST_LOCKED: begin
        if (hs_c && out_last_c) begin
          state_d   = ST_IDLE;
          rr_mask_d = mask_above(sel_c);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      rr_mask_q  <= '1;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_mask_q  <= rr_mask_d;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign bus.out_valid = rst_ni & out_valid_c;
  assign bus.in_ready  = rst_ni ? (grant_c & {N{bus.out_ready & out_valid_c}}) : '0;
  assign bus.out_sel   = rst_ni ? sel_c : '0;
  assign bus.out_data  = rst_ni ? out_data_c : '0;
  assign bus.out_last  = rst_ni & out_last_c;

  // A pending (stalled) beat must stay valid until it is accepted.
  a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_c && !bus.out_ready) |=> |(bus.in_valid & lock_oh_c))
    else $error("rr_stream_arbiter: selected requester dropped valid before handshake");
endmodule

// File: tb/tb_openip_rr_stream_arbiter.sv
// Directed bench for openip_rr_stream_arbiter: per-cycle vector table plus an
// asynchronous-reset-mid-packet sequence.
module tb_openip_rr_stream_arbiter;
  logic clk;
  logic rst_ni;

  openip_rr_stream_arbiter_if #(.NUM_INPUTS(4), .DATA_WIDTH(32)) bus ();

  openip_rr_stream_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        ready;
    logic [31:0] base;
    logic        exp_ov;
    logic [3:0]  exp_rdy;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                              input logic ready, input logic [31:0] base, input logic exp_ov,
                              input logic [3:0] exp_rdy, input logic [1:0] exp_sel);
    vec_t v;
    v.rst = rst; v.valid = valid; v.last = last; v.ready = ready; v.base = base;
    v.exp_ov = exp_ov; v.exp_rdy = exp_rdy; v.exp_sel = exp_sel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [3:0] last, input logic ready,
                       input logic [31:0] base);
    bus.in_valid  = valid;
    bus.in_last   = last;
    bus.out_ready = ready;
    for (int i = 0; i < 4; i++) bus.in_data[i*32 +: 32] = base + 32'(i);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);

    // Reset / priority
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 32'h000, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(0, 4'b1010, 4'b1111, 1, 32'h100, 1, 4'b0010, 2'd1));
    tbl.push_back(mk(0, 4'b1010, 4'b1111, 1, 32'h110, 1, 4'b1000, 2'd3));
    tbl.push_back(mk(0, 4'b1010, 4'b1111, 1, 32'h120, 1, 4'b0010, 2'd1));
    // Fairness: 0,1,2,3,0,1,2,3
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 32'h000, 0, 4'b0000, 2'd0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 32'h200 + 32'(k*16), 1,
                       4'(1 << (k % 4)), 2'(k % 4)));
    // Packet lock: input 1 completes, then input 2 sends A0,A1,A2 while input 0 waits
    tbl.push_back(mk(0, 4'b0010, 4'b1111, 1, 32'h300, 1, 4'b0010, 2'd1));
    tbl.push_back(mk(0, 4'b0101, 4'b1011, 1, 32'h09E, 1, 4'b0100, 2'd2));
    tbl.push_back(mk(0, 4'b0101, 4'b1011, 1, 32'h09F, 1, 4'b0100, 2'd2));
    tbl.push_back(mk(0, 4'b0101, 4'b1111, 1, 32'h0A0, 1, 4'b0100, 2'd2));
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 1, 32'h400, 1, 4'b0001, 2'd0));
    // Stall stability
    tbl.push_back(mk(1, 4'b0000, 4'b1111, 0, 32'h000, 0, 4'b0000, 2'd0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b0100, 4'b1111, 0, 32'h500, 1, 4'b0000, 2'd2));
    tbl.push_back(mk(0, 4'b0101, 4'b1111, 0, 32'h510, 1, 4'b0000, 2'd2));
    tbl.push_back(mk(0, 4'b0101, 4'b1111, 1, 32'h520, 1, 4'b0100, 2'd2));
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 1, 32'h530, 1, 4'b0001, 2'd0));
    // Bubble inside a packet
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 32'h000, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 32'h600, 1, 4'b0010, 2'd1));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 32'h610, 0, 4'b0000, 2'd1));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 32'h620, 0, 4'b0000, 2'd1));
    tbl.push_back(mk(0, 4'b1010, 4'b0010, 1, 32'h630, 1, 4'b0010, 2'd1));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 1, 32'h640, 1, 4'b1000, 2'd3));

    repeat (2) @(negedge clk);

    foreach (tbl[n]) begin
      @(negedge clk);
      rst_ni = ~tbl[n].rst;
      drive(tbl[n].valid, tbl[n].last, tbl[n].ready, tbl[n].base);
      #1;
      chk($sformatf("v%0d out_valid", n), 32'(bus.out_valid), 32'(tbl[n].exp_ov));
      chk($sformatf("v%0d in_ready", n), 32'(bus.in_ready), 32'(tbl[n].exp_rdy));
      chk($sformatf("v%0d out_sel", n), 32'(bus.out_sel), 32'(tbl[n].exp_sel));
      if (tbl[n].rst) begin
        chk($sformatf("v%0d out_data_rst", n), bus.out_data, 32'h0);
        chk($sformatf("v%0d out_last_rst", n), 32'(bus.out_last), 32'h0);
      end else if (tbl[n].exp_ov) begin
        chk($sformatf("v%0d out_data", n), bus.out_data, tbl[n].base + 32'(tbl[n].exp_sel));
        chk($sformatf("v%0d out_last", n), 32'(bus.out_last), 32'(tbl[n].last[tbl[n].exp_sel]));
      end
    end

    // Asynchronous reset between beats 1 and 2 of input 3's packet
    @(negedge clk);
    rst_ni = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1, 32'h700);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(4'b1000, 4'b0000, 1'b1, 32'h700);
    #1;
    chk("async beat1 sel", 32'(bus.out_sel), 32'd3);
    chk("async beat1 ready", 32'(bus.in_ready), 32'b1000);
    @(negedge clk);
    drive(4'b1001, 4'b0000, 1'b1, 32'h710);
    #1;
    chk("async locked sel", 32'(bus.out_sel), 32'd3);
    chk("async locked ready", 32'(bus.in_ready), 32'b1000);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("async rst out_sel", 32'(bus.out_sel), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(4'b1001, 4'b1111, 1'b1, 32'h720);
    #1;
    chk("post-rst sel", 32'(bus.out_sel), 32'd0);
    chk("post-rst ready", 32'(bus.in_ready), 32'b0001);
    chk("post-rst data", bus.out_data, 32'h720);
    @(negedge clk);
    #1;
    chk("post-rst next sel", 32'(bus.out_sel), 32'd3);
    chk("post-rst next ready", 32'(bus.in_ready), 32'b1000);

    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
